// File: rtl/wfifo_src_arbiter.sv
// Arbitrates NUM_SRC producers onto the single 16-bit wfifo write port, padding bursts to 8-beat words.
// Optional macro WFIFO_ARB_FIXED_PRIO_EN: lowest-index requester always wins (rr pointer held at 0).
`timescale 1ns/1ps

// state    | meaning
// ST_IDLE  | waiting for any request; winner latched here
// ST_LOAD  | wr_load high, downstream frame reset
// ST_FLUSH | wr_load low, waiting for the downstream reset to drain
// ST_XFER  | moving beats from the granted source
// ST_PAD   | filling the partial 128-bit word with PAD_WORD
// ST_ARB   | advance rr pointer, clear beat count
module wfifo_src_arbiter #(
  parameter int          NUM_SRC      = 2,
  parameter int          BURST_BEATS  = 64,
  parameter int          LOAD_CYCLES  = 4,
  parameter int          FLUSH_CYCLES = 24,
  parameter logic [15:0] PAD_WORD     = 16'h0000
) (
  input  logic                   wr_clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     i_src_req,
  input  logic [NUM_SRC-1:0]     i_src_sof,
  input  logic [NUM_SRC-1:0]     i_src_valid,
  input  logic [16*NUM_SRC-1:0]  i_src_data,
  input  logic [NUM_SRC-1:0]     i_src_last,
  output logic [NUM_SRC-1:0]     o_src_ready,
  input  logic                   i_fifo_afull,
  output logic                   o_wr_en,
  output logic [15:0]            o_wrdata,
  output logic                   o_wr_load,
  output logic [1:0]             o_grant_id,
  output logic                   o_busy
);

  localparam int CNT_W   = $clog2(BURST_BEATS) + 1;
  localparam int TMR_MAX = (LOAD_CYCLES > FLUSH_CYCLES) ? LOAD_CYCLES : FLUSH_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_BURST = CNT_W'(BURST_BEATS);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_FLUSH = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [1:0]       LAST_SRC  = 2'(NUM_SRC - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_XFER, ST_PAD, ST_ARB} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [1:0]        r_rr, w_rr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [15:0]       r_wrdata, w_wrdata_nxt;
  logic              r_wr_load;

  logic              w_sel_valid, w_sel_last;
  logic [15:0]       w_sel_data;
  logic              w_found, w_win_sof;
  logic [1:0]        w_win;
  logic              w_accept;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 2'(i)) begin
        w_sel_valid = i_src_valid[i];
        w_sel_last  = i_src_last[i];
        w_sel_data  = i_src_data[16*i +: 16];
      end
    end
  end

  // Two passes: indices at/after the pointer first, then wrap to the low indices.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_win_sof = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && (2'(j) >= r_rr) && i_src_req[j]) begin
        w_found   = 1'b1;
        w_win     = 2'(j);
        w_win_sof = i_src_sof[j];
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && i_src_req[j]) begin
        w_found   = 1'b1;
        w_win     = 2'(j);
        w_win_sof = i_src_sof[j];
      end
    end
  end

  always_comb begin
    o_src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      o_src_ready[i] = (r_state == ST_XFER) && (r_grant == 2'(i)) && !i_fifo_afull;
    end
  end

  assign w_accept = (r_state == ST_XFER) && w_sel_valid && !i_fifo_afull;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_nxt     = r_rr;
    w_cnt_nxt    = r_cnt;
    w_tmr_nxt    = r_tmr;
    w_wr_en_nxt  = 1'b0;
    w_wrdata_nxt = r_wrdata;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_win;
          if (w_win_sof) begin
            w_state_nxt = ST_LOAD;
            w_tmr_nxt   = TMR_LOAD;
          end else begin
            w_state_nxt = ST_XFER;
          end
        end
      end
      ST_LOAD: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_FLUSH;
          w_tmr_nxt   = TMR_FLUSH;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_FLUSH: begin
        if (r_tmr == '0) w_state_nxt = ST_XFER;
        else             w_tmr_nxt   = r_tmr - TMR_W'(1);
      end
      ST_XFER: begin
        if (w_accept) begin
          w_wr_en_nxt  = 1'b1;
          w_wrdata_nxt = w_sel_data;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          if ((w_cnt_nxt == CNT_BURST) || w_sel_last)
            w_state_nxt = (w_cnt_nxt[2:0] == 3'd0) ? ST_ARB : ST_PAD;
        end
      end
      ST_PAD: begin
        if (!i_fifo_afull) begin
          w_wr_en_nxt  = 1'b1;
          w_wrdata_nxt = PAD_WORD;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          if (w_cnt_nxt[2:0] == 3'd0) w_state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
`ifdef WFIFO_ARB_FIXED_PRIO_EN
        w_rr_nxt = '0;
`else
        w_rr_nxt = (r_grant == LAST_SRC) ? 2'd0 : r_grant + 2'd1;
`endif
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_wr_en   <= 1'b0;
      r_wrdata  <= '0;
      r_wr_load <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr      <= w_rr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmr     <= w_tmr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wrdata  <= w_wrdata_nxt;
      r_wr_load <= (w_state_nxt == ST_LOAD);
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wrdata   = r_wrdata;
  assign o_wr_load  = r_wr_load;
  assign o_grant_id = r_grant;
  assign o_busy     = (r_state != ST_IDLE);

endmodule
